// File: rtl/serial_parity_checker.sv
// Serial parity checker: DATA_W data bits LSB first followed by one parity bit,
// odd/even selectable per frame, with per-frame error pulse and error accounting.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              sof,
    input  logic              odd_mode,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              e,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              mode_reg, mode_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              frame_done_reg, frame_done_next;
    logic              e_reg, e_next;
    logic              err_sticky_reg, err_sticky_next;
    logic [CNT_W-1:0]  err_cnt_reg, err_cnt_next;
    logic [CNT_W-1:0]  err_cnt_base;

    logic accept_sof;
    logic load_data;
    logic take_parity;
    logic last_data;
    logic parity_x;
    logic frame_err;

    // A valid sof restarts the frame from any state, so it takes priority
    // over normal data/parity handling.
    assign accept_sof  = in_valid & sof;
    assign load_data   = in_valid & ~sof & (state_reg == DATA);
    assign take_parity = in_valid & ~sof & (state_reg == PARITY);
    assign last_data   = (cnt_reg == CW'(DATA_W - 1));
    assign parity_x    = (^data_reg) ^ in_bit;
    assign frame_err   = take_parity & (parity_x ^ mode_reg);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data_bit
            if (gi == 0) begin : g_first
                assign data_next[gi] = accept_sof ? in_bit :
                                       (load_data && (cnt_reg == CW'(gi))) ? in_bit :
                                       data_reg[gi];
            end else begin : g_rest
                assign data_next[gi] = accept_sof ? 1'b0 :
                                       (load_data && (cnt_reg == CW'(gi))) ? in_bit :
                                       data_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        mode_next       = mode_reg;
        data_out_next   = data_out_reg;
        frame_done_next = 1'b0;
        e_next          = 1'b0;
        if (accept_sof) begin
            mode_next  = odd_mode;
            cnt_next   = CW'(1);
            state_next = (DATA_W == 1) ? PARITY : DATA;
        end else if (load_data) begin
            cnt_next = cnt_reg + CW'(1);
            if (last_data) begin
                state_next = PARITY;
            end
        end else if (take_parity) begin
            frame_done_next = 1'b1;
            e_next          = frame_err;
            data_out_next   = data_reg;
            cnt_next        = '0;
            state_next      = IDLE;
        end else if ((state_reg != IDLE) && (state_reg != DATA) && (state_reg != PARITY)) begin
            state_next = IDLE;
        end
    end

    // Clear is applied before the increment so a coincident error still counts.
    always_comb begin
        err_cnt_base    = clr_err ? '0 : err_cnt_reg;
        err_cnt_next    = err_cnt_base;
        err_sticky_next = err_sticky_reg & ~clr_err;
        if (frame_err) begin
            err_sticky_next = 1'b1;
            if (err_cnt_base != CNT_MAX) begin
                err_cnt_next = err_cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mode_reg       <= 1'b0;
            data_reg       <= '0;
            data_out_reg   <= '0;
            frame_done_reg <= 1'b0;
            e_reg          <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mode_reg       <= mode_next;
            data_reg       <= data_next;
            data_out_reg   <= data_out_next;
            frame_done_reg <= frame_done_next;
            e_reg          <= e_next;
            err_sticky_reg <= err_sticky_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign data_out   = data_out_reg;
    assign frame_done = frame_done_reg;
    assign e          = e_reg;
    assign err_sticky = err_sticky_reg;
    assign err_cnt    = err_cnt_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker across several DATA_W/CNT_W builds
// sharing one input stream; each test group targets one instance.
module tb_serial_parity_checker;

    logic clk = 1'b0;
    logic rst, in_valid, in_bit, sof, odd_mode, clr_err;

    logic [2:0] do3;  logic fd3, e3, st3, b3;   logic [7:0] cnt3;
    logic [7:0] do8;  logic fd8, e8, st8, b8;   logic [7:0] cnt8;
    logic [7:0] do8s; logic fd8s, e8s, st8s, b8s; logic [1:0] cnt8s;
    logic [0:0] do1;  logic fd1, e1, st1, b1;   logic [7:0] cnt1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fd3_cnt = 0;
    int fd8_cnt = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_W(3), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .sof(sof),
        .odd_mode(odd_mode), .clr_err(clr_err), .data_out(do3), .frame_done(fd3),
        .e(e3), .err_sticky(st3), .err_cnt(cnt3), .busy(b3));
    serial_parity_checker #(.DATA_W(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .sof(sof),
        .odd_mode(odd_mode), .clr_err(clr_err), .data_out(do8), .frame_done(fd8),
        .e(e8), .err_sticky(st8), .err_cnt(cnt8), .busy(b8));
    serial_parity_checker #(.DATA_W(8), .CNT_W(2)) u8s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .sof(sof),
        .odd_mode(odd_mode), .clr_err(clr_err), .data_out(do8s), .frame_done(fd8s),
        .e(e8s), .err_sticky(st8s), .err_cnt(cnt8s), .busy(b8s));
    serial_parity_checker #(.DATA_W(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .sof(sof),
        .odd_mode(odd_mode), .clr_err(clr_err), .data_out(do1), .frame_done(fd1),
        .e(e1), .err_sticky(st1), .err_cnt(cnt1), .busy(b1));

    always @(negedge clk) begin
        if (fd3) fd3_cnt++;
        if (fd8) fd8_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       odd;
        logic       exp_e;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; sof = 1'b0; clr_err = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic s, input logic m, input logic c);
        in_valid = 1'b1; in_bit = b; sof = s; odd_mode = m; clr_err = c;
        step();
        in_valid = 1'b0; in_bit = 1'b0; sof = 1'b0; clr_err = 1'b0;
    endtask

    // Gap cycles drive junk on in_bit/sof with in_valid low; all must be ignored.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0; sof = 1'($urandom); in_bit = 1'($urandom);
            step();
        end
        sof = 1'b0; in_bit = 1'b0;
    endtask

    // odd_mode is inverted on every bit after sof to show it is only sampled at sof.
    task automatic send_data(input logic [7:0] data, input int n, input logic odd, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 2));
            send_bit(data[i], i == 0, (i == 0) ? odd : ~odd, 1'b0);
        end
    endtask

    task automatic send_par(input logic par, input logic odd, input logic gaps, input logic clr);
        if (gaps) idle($urandom_range(1, 2));
        send_bit(par, 1'b0, ~odd, clr);
        $display("frame parity_bit=%0b odd=%0b clr=%0b", par, odd, clr);
    endtask

    task automatic send_frame(input logic [7:0] data, input int n, input logic par,
                              input logic odd, input logic gaps, input logic clr);
        send_data(data, n, odd, gaps);
        send_par(par, odd, gaps, clr);
    endtask

    initial begin
        logic [15:0] legacy_mask;
        logic [3:0]  v;
        int          base;
        int          exp_sat [5];

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'd1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[7] = '{8'h7F, 1'b0, 1'b0, 1'b1, 8'd3};
        legacy_mask = 16'b1001_0110_0110_1001;
        exp_sat = '{1, 2, 3, 3, 3};

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; sof = 1'b0; odd_mode = 1'b0; clr_err = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_data_out", do8, 0);
        check("rst_frame_done", fd8, 0);
        check("rst_e", e8, 0);
        check("rst_sticky", st8, 0);
        check("rst_cnt", cnt8, 0);
        check("rst_busy", b8, 0);

        // Legacy 3-bit odd parity: all 16 frames back to back.
        do_reset();
        base = fd3_cnt;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            send_frame({5'b0, v[2:0]}, 3, v[3], 1'b1, 1'b0, 1'b0);
            check($sformatf("legacy_fd_%0d", i), fd3, 1);
            check($sformatf("legacy_e_%0d", i), e3, legacy_mask[i]);
            check($sformatf("legacy_data_%0d", i), do3, v[2:0]);
        end
        idle(1);
        check("legacy_fd_after", fd3, 0);
        check("legacy_cnt", cnt3, 8);
        check("legacy_sticky", st3, 1);
        check("legacy_fd_total", fd3_cnt - base, 16);

        // DATA_W=8 table.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send_data(vecs[k].data, 8, vecs[k].odd, 1'b0);
            check($sformatf("vec_busy_pre_%0d", k), b8, 1);
            check($sformatf("vec_fd_pre_%0d", k), fd8, 0);
            send_par(vecs[k].par, vecs[k].odd, 1'b0, 1'b0);
            check($sformatf("vec_fd_%0d", k), fd8, 1);
            check($sformatf("vec_e_%0d", k), e8, vecs[k].exp_e);
            check($sformatf("vec_data_%0d", k), do8, vecs[k].data);
            check($sformatf("vec_cnt_%0d", k), cnt8, vecs[k].exp_cnt);
            check($sformatf("vec_busy_%0d", k), b8, 0);
        end

        // Gaps everywhere.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        check("gap_fd", fd8, 1);
        check("gap_e", e8, 0);
        check("gap_data", do8, 8'hA5);
        check("gap_cnt", cnt8, 3);

        // Abort in DATA then in PARITY; each followed by a complete 0x3C odd frame.
        idle(1);
        base = fd8_cnt;
        send_data(8'h0F, 4, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_fd", fd8, 1);
        check("abort_e", e8, 0);
        check("abort_data", do8, 8'h3C);
        send_data(8'hFF, 8, 1'b0, 1'b0);
        check("abort_in_parity_busy", b8, 1);
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b0);
        check("abort2_e", e8, 0);
        idle(1);
        check("abort_fd_total", fd8_cnt - base, 2);
        check("abort_cnt", cnt8, 3);

        // Reset mid-frame.
        base = fd8_cnt;
        send_data(8'h55, 5, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_data", do8, 0);
        check("midrst_fd", fd8, 0);
        check("midrst_e", e8, 0);
        check("midrst_sticky", st8, 0);
        check("midrst_cnt", cnt8, 0);
        check("midrst_busy", b8, 0);
        idle(3);
        check("midrst_no_fd", fd8_cnt - base, 0);
        send_frame(8'h3C, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        check("postrst_fd", fd8, 1);
        check("postrst_e", e8, 1);
        check("postrst_data", do8, 8'h3C);
        check("postrst_cnt", cnt8, 1);

        // Saturation and clear on the CNT_W=2 build.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("sat_e_%0d", k), e8s, 1);
            check($sformatf("sat_cnt_%0d", k), cnt8s, exp_sat[k]);
        end
        check("sat_sticky", st8s, 1);
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_coinc_cnt", cnt8s, 1);
        check("clr_coinc_sticky", st8s, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_alone_cnt", cnt8s, 0);
        check("clr_alone_sticky", st8s, 0);

        // DATA_W=1 edge.
        do_reset();
        check("w1_rst_busy", b1, 0);
        send_data(8'h01, 1, 1'b1, 1'b0);
        check("w1_busy", b1, 1);
        send_par(1'b0, 1'b1, 1'b0, 1'b0);
        check("w1_fd_a", fd1, 1);
        check("w1_e_a", e1, 0);
        check("w1_data_a", do1, 1);
        send_frame(8'h01, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("w1_fd_b", fd1, 1);
        check("w1_e_b", e1, 1);
        check("w1_cnt_b", cnt1, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
